fixed_point_mac_acc: RTL and testbench
======================================

# fixed_point_mac_acc

Downstream consumer of the fixed-point multiplier. It takes the signed 2*WIDTH-bit products (already shifted right by DEC_POINT_POS) over a valid/ready stream and accumulates them in a guard-bit accumulator. At the end of each vector it requantizes the sum back to a WIDTH-bit signed operand. It closes the multiply loop into a dot-product / MAC datapath, and its output format matches the multiplier's input operands.

## Interface
- WIDTH, 8: operand width; product input is 2*WIDTH bits.
- GUARD, 8: accumulator guard bits; ACC_WIDTH = 2*WIDTH+GUARD.
- CNT_WIDTH, 8: beat-counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a beat.
- in_prod  in  2*WIDTH  signed product, same fraction position as operands.
- in_last  in  1  final beat of the current vector, qualified by in_valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  signed requantized sum.
- out_ovf  out  1  result clipped to WIDTH, or accumulator/counter overflow occurred in this vector.
- out_cnt  out  CNT_WIDTH  number of beats in the vector, saturating at all-ones.

## Operation
- States: ACC (accepting beats) and HOLD (result presented).
- ACC:
  - in_ready = 1.
  - On an accepted beat (in_valid & in_ready): acc <= acc + sext(in_prod); cnt <= cnt+1, saturating.
  - Sticky ovf_acc is set if the ACC_WIDTH signed add overflows. The accumulator then clamps to its max/min.
- ACC, accepted beat with in_last = 1:
  - final = acc + sext(in_prod), with the same clamping rule.
  - Register out_data = requant(final), out_cnt = cnt+1, out_ovf = ovf_acc | clip | cnt_sat.
  - Go to HOLD. acc, cnt and ovf_acc clear in the same edge.
- HOLD:
  - in_ready = 0.
  - out_valid = 1; out_data, out_cnt and out_ovf are held stable.
  - On out_ready, go to ACC and set out_valid = 0.
- requant(x): the value range is [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Behaviour is set by ACC_SAT_EN (see Configuration).
  - clip = 1 when x lies outside that range.
- A vector of length 1 (in_last on its first beat) is legal. It yields requant(in_prod) with out_cnt = 1.
- Beats with in_valid = 0 are ignored. An in_last without in_valid has no effect.

## Timing
- Reset (rst_n low at a clock edge):
  - state = ACC; acc = 0, cnt = 0, ovf_acc = 0.
  - out_valid = 0, out_data = 0, out_cnt = 0, out_ovf = 0.
  - in_ready is 0 during reset and 1 from the first cycle after release.
- Reset mid-vector or during HOLD discards the partial sum or the pending result. No out_valid is produced for it.
- Throughput: one beat per cycle while in ACC.
- Latency: out_valid rises in the cycle after the in_last beat is accepted.
- Vector gap: out_ready is sampled in HOLD. With out_ready held high, HOLD lasts exactly 1 cycle, and the next vector's first beat can be accepted 2 cycles after the last beat. There is no pass-through from out_ready to in_ready in the same cycle.
- out_* outputs are registered. in_ready is decoded from state only.
- out_valid, once high, stays high with stable data until out_ready is sampled high.

## Configuration
- ACC_SAT_EN defined: requant clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1); clip is reported in out_ovf.
- ACC_SAT_EN undefined: requant wraps, out_data = x[WIDTH-1:0]. clip is still computed and reported in out_ovf, so overflow stays observable.
- The accumulator-internal clamp and cnt saturation are independent of the macro.

## Structure
- Shared package fixed_point_pkg:
  - State enum (ST_ACC, ST_HOLD).
  - ACC_WIDTH derivation function.
  - Signed MAX/MIN constant functions for a given width.
- One sub-module, fixed_point_requant: purely combinational ACC_WIDTH to WIDTH saturate/wrap plus clip flag. It is reused wherever a wide result returns to operand width.
- The top level holds the FSM, accumulator, counter and output registers.

## Test plan
All scenarios use WIDTH = 8.
- Basic sum: beats 64, 32(last), out_ready high. Result: out_data = 96, out_cnt = 2, out_ovf = 0, out_valid 1 cycle after the last beat.
- Positive overflow: beats 100, 50(last). With ACC_SAT_EN: out_data = 127, out_ovf = 1. Without: out_data = -106, out_ovf = 1.
- Negative overflow and single beat: -100, -60(last) gives -128 (sat) with out_ovf = 1. A single beat -5(last) gives -5, out_cnt = 1, out_ovf = 0.
- Backpressure: hold out_ready low for 3 cycles in HOLD while in_valid stays high. Result: in_ready = 0 and out_data/out_cnt stable all 3 cycles; no beat is consumed; the next vector starts correctly after the handshake.
- Reset mid-vector: beats 10, 20, then rst_n low 1 cycle, then 7(last). Result: out_data = 7, out_cnt = 1; no output for the aborted vector.
- Counter and accumulator stress: 300 beats of +16383 before last. Result: out_cnt = 255 (saturated), out_ovf = 1, out_data = 127 (sat).

Source files
------------

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared FSM state type and width/limit helpers for the fixed-point MAC path
package fixed_point_pkg;
    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    function automatic logic signed [63:0] smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/fixed_point_requant.sv
// fixed_point_requant: wide signed value to WIDTH bits; saturates when ACC_SAT_EN is defined, else wraps
module fixed_point_requant
    import fixed_point_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IN_WIDTH = 24
) (
    input  logic signed [IN_WIDTH-1:0] x,
    output logic signed [WIDTH-1:0]    y,
    output logic                       clip
);
    localparam logic signed [IN_WIDTH-1:0] QMAX = IN_WIDTH'(smax(WIDTH));
    localparam logic signed [IN_WIDTH-1:0] QMIN = IN_WIDTH'(smin(WIDTH));

    logic hi, lo;

    assign hi   = x > QMAX;
    assign lo   = x < QMIN;
    assign clip = hi || lo;
`ifdef ACC_SAT_EN
    assign y = hi ? QMAX[WIDTH-1:0] : lo ? QMIN[WIDTH-1:0] : x[WIDTH-1:0];
`else
    assign y = x[WIDTH-1:0];
`endif
endmodule

// File: rtl/fixed_point_mac_acc.sv
// fixed_point_mac_acc: guard-bit accumulator over a product stream, requantized per vector
// ACC_SAT_EN selects saturating (defined) or wrapping (undefined) requantization.
module fixed_point_mac_acc
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GUARD     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [2*WIDTH-1:0]   in_prod,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH-1:0]     out_data,
    output logic                        out_ovf,
    output logic [CNT_WIDTH-1:0]        out_cnt
);
    localparam int AW = acc_width(WIDTH, GUARD);
    localparam logic signed [AW-1:0] AMAX = AW'(smax(AW));
    localparam logic signed [AW-1:0] AMIN = AW'(smin(AW));

    state_t                  state;
    logic signed [AW-1:0]    acc, sum;
    logic signed [AW:0]      wide;
    logic [CNT_WIDTH-1:0]    cnt, cnt_nxt;
    logic                    ovf_acc, add_ovf, cnt_full, clip, fire;
    logic signed [WIDTH-1:0] q;

    assign in_ready = rst_n && state == ST_ACC;
    assign fire     = in_valid && in_ready;
    // one extra bit exposes signed overflow of the ACC_WIDTH add
    assign wide     = (AW+1)'(acc) + (AW+1)'(in_prod);
    assign add_ovf  = wide[AW] ^ wide[AW-1];
    assign sum      = add_ovf ? (wide[AW] ? AMIN : AMAX) : wide[AW-1:0];
    assign cnt_full = &cnt;
    assign cnt_nxt  = cnt_full ? cnt : cnt + 1'b1;

    fixed_point_requant #(.WIDTH(WIDTH), .IN_WIDTH(AW)) u_requant (
        .x    (sum),
        .y    (q),
        .clip (clip)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ST_HOLD) begin
            if (out_ready) begin
                state     <= ST_ACC;
                out_valid <= 1'b0;
            end
        end else if (fire) begin
            if (in_last) begin
                state     <= ST_HOLD;
                out_valid <= 1'b1;
                out_data  <= q;
                out_cnt   <= cnt_nxt;
                out_ovf   <= ovf_acc || add_ovf || clip || cnt_full;
                acc       <= '0;
                cnt       <= '0;
                ovf_acc   <= 1'b0;
            end else begin
                acc     <= sum;
                cnt     <= cnt_nxt;
                ovf_acc <= ovf_acc || add_ovf;
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_mac_acc.sv
// tb_fixed_point_mac_acc: scoreboard bench for fixed_point_mac_acc with WIDTH=8
module tb_fixed_point_mac_acc;
    typedef struct {
        logic signed [7:0] d;
        logic [7:0]        c;
        logic              o;
    } exp_t;

    logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic signed [15:0] in_prod = '0;
    logic in_ready, out_valid, out_ovf;
    logic signed [7:0] out_data;
    logic [7:0] out_cnt;

    exp_t sb[$];
    int passed = 0, total = 0;

    fixed_point_mac_acc #(.WIDTH(8), .GUARD(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    // reference: 24-bit clamped accumulation, saturating count, 8-bit requant
    function automatic exp_t model(input int vals[$]);
        exp_t e;
        longint acc = 0;
        bit ovf = 0, clip;
        int n = 0;
        foreach (vals[i]) begin
            acc += vals[i];
            if (acc > 8388607) begin acc = 8388607; ovf = 1; end
            else if (acc < -8388608) begin acc = -8388608; ovf = 1; end
            n++;
        end
        if (n > 255) ovf = 1;
        clip = acc > 127 || acc < -128;
        e.c = (n > 255) ? 8'd255 : 8'(n);
        e.o = ovf | clip;
`ifdef ACC_SAT_EN
        e.d = acc > 127 ? 8'sd127 : acc < -128 ? -8'sd128 : 8'(acc);
`else
        e.d = 8'(acc);
`endif
        return e;
    endfunction

    task automatic send(input int vals[$]);
        sb.push_back(model(vals));
        foreach (vals[i]) begin
            in_valid = 1;
            in_prod  = 16'(vals[i]);
            in_last  = (i == vals.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic collect(output logic signed [7:0] d, output logic [7:0] c, output logic o, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!out_valid) lat = -1;
        d = out_data; c = out_cnt; o = out_ovf;
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'sd0) $display("FAIL reset out_data: got %0d want 0", out_data); else passed++;
        total++; if (out_cnt !== 8'd0) $display("FAIL reset out_cnt: got %0d want 0", out_cnt); else passed++;
        total++; if (out_ovf !== 1'b0) $display("FAIL reset out_ovf: got %b want 0", out_ovf); else passed++;
        rst_n = 1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset release in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_vector(input string name, input int vals[$]);
        logic signed [7:0] d; logic [7:0] c; logic o; int lat; exp_t e;
        send(vals);
        total++; if (in_ready !== 1'b0) $display("FAIL %s hold in_ready: got %b want 0", name, in_ready); else passed++;
        collect(d, c, o, lat);
        e = sb.pop_front();
        total++; if (lat !== 0) $display("FAIL %s latency: got %0d want 0", name, lat); else passed++;
        total++; if (d !== e.d) $display("FAIL %s data: got %0d want %0d", name, d, e.d); else passed++;
        total++; if (c !== e.c) $display("FAIL %s cnt: got %0d want %0d", name, c, e.c); else passed++;
        total++; if (o !== e.o) $display("FAIL %s ovf: got %b want %b", name, o, e.o); else passed++;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL %s release: got valid=%b ready=%b want 0/1", name, out_valid, in_ready); else passed++;
    endtask

    task automatic test_backpressure;
        logic signed [7:0] d; logic [7:0] c; logic o; int lat; exp_t e;
        out_ready = 0;
        send('{3, 4});
        e = sb[0];
        in_valid = 1; in_prod = 16'sd99; in_last = 1;
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL bp cycle%0d: got ready=%b valid=%b want 0/1", i, in_ready, out_valid); else passed++;
            total++; if (out_data !== e.d || out_cnt !== e.c) $display("FAIL bp stable%0d: got %0d/%0d want %0d/%0d", i, out_data, out_cnt, e.d, e.c); else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1;
        collect(d, c, o, lat);
        in_valid = 0; in_last = 0;
        e = sb.pop_front();
        total++; if (d !== e.d || c !== e.c || o !== e.o) $display("FAIL bp result: got %0d/%0d/%b want %0d/%0d/%b", d, c, o, e.d, e.c, e.o); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL bp release: got %b want 0", out_valid); else passed++;
        test_vector("bp_next", '{5});
    endtask

    task automatic test_reset_mid;
        in_valid = 1; in_last = 0;
        in_prod = 16'sd10; @(posedge clk); #1;
        in_prod = 16'sd20; @(posedge clk); #1;
        in_valid = 0; rst_n = 0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL rstmid during: got valid=%b ready=%b want 0/0", out_valid, in_ready); else passed++;
        rst_n = 1;
        test_vector("rstmid", '{7});
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++) begin
            int vals[$];
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(0, 400)) - 200);
            test_vector($sformatf("b2b%0d", k), vals);
        end
    endtask

    initial begin
        int big[$];
        test_reset;
        test_vector("basic", '{64, 32});
        test_vector("posovf", '{100, 50});
        test_vector("negovf", '{-100, -60});
        test_vector("single", '{-5});
        test_backpressure;
        test_reset_mid;
        big = {};
        repeat (301) big.push_back(16383);
        test_vector("cntsat", big);
        big = {};
        repeat (520) big.push_back(16383);
        repeat (520) big.push_back(-16383);
        test_vector("accclamp", big);
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
